// File: rtl/led_mode_sequencer.sv
// Key debouncer: 2-FF sync, stable-count filter, one-cycle press pulse on a debounced 1->0 transition.
// Latency: press pulse DEBOUNCE_CYC+3 edges after the pad is first sampled low; no backpressure.
module led_key_debounce #(
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic press
);
    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync1;
    logic          sync2;
    logic          deb;
    logic          deb_d;
    logic          armed;
    logic [1:0]    settle;
    logic [CW-1:0] cnt;

    // A key held through reset must be seen released before it may generate a press.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            deb    <= 1'b1;
            deb_d  <= 1'b1;
            armed  <= 1'b0;
            settle <= 2'd0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
            deb_d <= deb;
            if (settle != 2'd2) begin
                settle <= settle + 2'd1;
            end
            if (settle == 2'd2 && sync2) begin
                armed <= 1'b1;
            end
            if (sync2 == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                deb <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            press <= armed & deb_d & ~deb;
        end
    end
endmodule

// led_mode_sequencer: debounced key control of a four-mode LED bar pattern (RUN sweep, FLASH, ALL_ON, OFF).
// Latency: key press to mode change DEBOUNCE_CYC+4 edges, step/mode change to LED one edge; no backpressure.
module led_mode_sequencer #(
    parameter int LED_W        = 8,
    parameter int TICK_DIV     = 10000000,
    parameter int FLASH_DIV    = 5000000,
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             key0,
    input  logic             key1,
    output logic [LED_W-1:0] led_o,
    output logic [1:0]       mode_o,
    output logic             paused_o,
    output logic             tick_o
);
    typedef enum logic [1:0] {
        MODE_RUN    = 2'd0,
        MODE_FLASH  = 2'd1,
        MODE_ALL_ON = 2'd2,
        MODE_OFF    = 2'd3
    } mode_t;

    localparam int DIV_MAX = (TICK_DIV > FLASH_DIV) ? TICK_DIV : FLASH_DIV;
    localparam int PW      = $clog2(DIV_MAX);
    localparam logic [PW-1:0]    TICK_LAST  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]    FLASH_LAST = PW'(FLASH_DIV - 1);
    localparam logic [LED_W-1:0] ONES       = {LED_W{1'b1}};

    logic             press0;
    logic             press1;
    mode_t            mode;
    logic             paused;
    logic [PW-1:0]    presc;
    logic [LED_W-1:0] run_pat;
    logic             dir_down;
    logic             phase;

    logic             mode_chg;
    logic             counting;
    logic [PW-1:0]    div_last;
    logic             step;
    logic [LED_W-1:0] pattern;

    led_key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key0 (
        .clk   (sys_clk),
        .rst_n (rst_n),
        .key   (key0),
        .press (press0)
    );

    led_key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key1 (
        .clk   (sys_clk),
        .rst_n (rst_n),
        .key   (key1),
        .press (press1)
    );

    // Every key1 press changes mode: alone it advances, with key0 it forces RUN.
    always_comb begin
        mode_chg = press1;
        counting = (mode == MODE_RUN || mode == MODE_FLASH) && !paused && !mode_chg;
        div_last = (mode == MODE_FLASH) ? FLASH_LAST : TICK_LAST;
        step     = counting && (presc == div_last);
        pattern  = '0;
        case (mode)
            MODE_RUN:    pattern = run_pat;
            MODE_FLASH:  pattern = phase ? ONES : '0;
            MODE_ALL_ON: pattern = ONES;
            default:     pattern = '0;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            led_o    <= ONES;
            tick_o   <= 1'b0;
            mode     <= MODE_RUN;
            paused   <= 1'b0;
            presc    <= '0;
            run_pat  <= '0;
            dir_down <= 1'b0;
            phase    <= 1'b0;
        end else begin
            led_o  <= ~pattern;
            tick_o <= step;

            if (press0 && press1) begin
                mode   <= MODE_RUN;
                paused <= 1'b0;
            end else if (press1) begin
                mode <= mode_t'(mode + 2'd1);
            end else if (press0) begin
                paused <= ~paused;
            end

            if (mode_chg) begin
                presc    <= '0;
                run_pat  <= '0;
                dir_down <= 1'b0;
                phase    <= 1'b0;
            end else if (counting) begin
                if (step) begin
                    presc <= '0;
                    if (mode == MODE_FLASH) begin
                        phase <= ~phase;
                    end else if (!dir_down) begin
                        // Reaching the end only flips direction, giving a one-step dwell.
                        if (run_pat == ONES) begin
                            dir_down <= 1'b1;
                        end else begin
                            run_pat <= {run_pat[LED_W-2:0], 1'b1};
                        end
                    end else begin
                        if (run_pat == '0) begin
                            dir_down <= 1'b0;
                        end else begin
                            run_pat <= {1'b0, run_pat[LED_W-1:1]};
                        end
                    end
                end else begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end

    assign mode_o   = mode;
    assign paused_o = paused;
endmodule

// File: tb/tb_led_mode_sequencer.sv
// Bench for led_mode_sequencer: directed key scenarios plus random key/reset traffic,
// checked every cycle against a step-count/sample-window reference model.
module tb_led_mode_sequencer;
    localparam int LED_W     = 8;
    localparam int TICK_DIV  = 4;
    localparam int FLASH_DIV = 3;
    localparam int DEB       = 3;
    localparam int PERIOD    = 2 * LED_W + 2;

    logic             sys_clk = 1'b0;
    logic             rst_n   = 1'b0;
    logic             key0    = 1'b1;
    logic             key1    = 1'b1;
    logic [LED_W-1:0] led_o;
    logic [1:0]       mode_o;
    logic             paused_o;
    logic             tick_o;

    led_mode_sequencer #(
        .LED_W        (LED_W),
        .TICK_DIV     (TICK_DIV),
        .FLASH_DIV    (FLASH_DIV),
        .DEBOUNCE_CYC (DEB)
    ) dut (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .key0     (key0),
        .key1     (key1),
        .led_o    (led_o),
        .mode_o   (mode_o),
        .paused_o (paused_o),
        .tick_o   (tick_o)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: RUN pattern is a pure function of the step index within an 18-step cycle.
    function automatic logic [LED_W-1:0] run_pattern(input int s);
        logic [LED_W-1:0] ones;
        ones = {LED_W{1'b1}};
        if (s <= LED_W) return LED_W'((1 << s) - 1);
        if (s == LED_W + 1) return ones;
        return ones >> (s - LED_W - 1);
    endfunction

    function automatic logic [LED_W-1:0] pattern_of(input int mode, input int s, input int phase);
        case (mode)
            0:       return run_pattern(s);
            1:       return (phase != 0) ? {LED_W{1'b1}} : '0;
            2:       return {LED_W{1'b1}};
            default: return '0;
        endcase
    endfunction

    bit               m_valid = 0;
    logic [LED_W-1:0] m_led;
    int               m_mode;
    logic             m_paused;
    logic             m_tick;
    int               m_s, m_phase, m_act, edge_n;
    bit               m_deb [2];
    bit               hist [2][DEB+1];
    bit               seen_rel [2];
    int               ev_edge [2];

    // Debounced level flips once the DEB pad samples taken 2..DEB+1 edges ago all disagree with it.
    always @(posedge sys_clk) begin : model_blk
        bit pad [2];
        bit ev [2];
        bit all_diff;
        bit step;
        pad[0] = key0;
        pad[1] = key1;
        if (!rst_n) begin
            m_valid = 1; m_led = '1; m_mode = 0; m_paused = 0; m_tick = 0;
            m_s = 0; m_phase = 0; m_act = 0; edge_n = 0;
            for (int k = 0; k < 2; k++) begin
                m_deb[k] = 1; seen_rel[k] = 0; ev_edge[k] = -1;
                for (int i = 0; i <= DEB; i++) hist[k][i] = 1;
            end
        end else if (m_valid) begin
            edge_n++;
            for (int k = 0; k < 2; k++) begin
                ev[k] = (ev_edge[k] == edge_n);
                if (edge_n >= 3 && hist[k][1]) seen_rel[k] = 1;
                all_diff = 1;
                for (int i = 1; i <= DEB; i++) if (hist[k][i] == m_deb[k]) all_diff = 0;
                if (all_diff) begin
                    if (m_deb[k] && seen_rel[k]) ev_edge[k] = edge_n + 2;
                    m_deb[k] = !m_deb[k];
                end
                for (int i = DEB; i >= 1; i--) hist[k][i] = hist[k][i-1];
                hist[k][0] = pad[k];
            end

            m_led = ~pattern_of(m_mode, m_s, m_phase);
            step = 0;
            if (ev[1]) begin
                m_mode = ev[0] ? 0 : (m_mode + 1) % 4;
                if (ev[0]) m_paused = 0;
                m_s = 0; m_phase = 0; m_act = 0;
            end else begin
                if (m_mode < 2 && !m_paused) begin
                    m_act++;
                    if (m_act == ((m_mode == 0) ? TICK_DIV : FLASH_DIV)) begin
                        m_act = 0;
                        step = 1;
                        if (m_mode == 0) m_s = (m_s + 1) % PERIOD;
                        else m_phase = 1 - m_phase;
                    end
                end
                if (ev[0]) m_paused = !m_paused;
            end
            m_tick = step;
        end
    end

    always @(negedge sys_clk) begin
        if (m_valid) begin
            chk("model_led", led_o, m_led);
            chk("model_mode", mode_o, m_mode);
            chk("model_paused", paused_o, m_paused);
            chk("model_tick", tick_o, m_tick);
        end
    end

    task automatic press(input bit k0, input bit k1, input int low_cyc, input int high_cyc);
        key0 = !k0;
        key1 = !k1;
        repeat (low_cyc) @(negedge sys_clk);
        key0 = 1'b1;
        key1 = 1'b1;
        repeat (high_cyc) @(negedge sys_clk);
    endtask

    initial begin
        int r, dur;
        rst_n = 1'b0;
        key0  = 1'b1;
        key1  = 1'b1;
        repeat (3) @(negedge sys_clk);
        chk("rst_led", led_o, 8'hFF);
        chk("rst_mode", mode_o, 0);
        chk("rst_paused", paused_o, 0);
        chk("rst_tick", tick_o, 0);
        rst_n = 1'b1;

        // RUN sweep from reset release: step every TICK_DIV edges, LED follows one edge later.
        repeat (4) @(posedge sys_clk);
        #1;
        chk("first_tick", tick_o, 1);
        chk("led_before_step", led_o, 8'hFF);
        @(posedge sys_clk);
        #1;
        chk("led_step1", led_o, 8'hFE);
        chk("tick_after", tick_o, 0);
        repeat (4) @(posedge sys_clk);
        #1;
        chk("led_step2", led_o, 8'hFC);
        repeat (28) @(posedge sys_clk);
        #1;
        chk("led_dwell_top", led_o, 8'h00);
        repeat (4) @(posedge sys_clk);
        #1;
        chk("led_first_down", led_o, 8'h80);

        // Short glitch must not register; a held key advances exactly once at edge DEB+4.
        @(negedge sys_clk);
        press(1'b0, 1'b1, 2, 10);
        chk("glitch_mode", mode_o, 0);
        key1 = 1'b0;
        repeat (6) @(posedge sys_clk);
        #1;
        chk("hold_edge6_mode", mode_o, 0);
        @(posedge sys_clk);
        #1;
        chk("hold_edge7_mode", mode_o, 1);
        repeat (3) @(negedge sys_clk);
        key1 = 1'b1;
        repeat (15) @(negedge sys_clk);
        chk("release_no_event", mode_o, 1);

        // One-cycle reset mid-FLASH with key1 held: no press until it is released and pressed again.
        key1 = 1'b0;
        repeat (3) @(negedge sys_clk);
        rst_n = 1'b0;
        @(posedge sys_clk);
        #1;
        chk("midrst_led", led_o, 8'hFF);
        chk("midrst_mode", mode_o, 0);
        chk("midrst_paused", paused_o, 0);
        chk("midrst_tick", tick_o, 0);
        @(negedge sys_clk);
        rst_n = 1'b1;
        repeat (20) @(negedge sys_clk);
        chk("held_after_rst_mode", mode_o, 0);
        key1 = 1'b1;
        repeat (6) @(negedge sys_clk);
        press(1'b0, 1'b1, 6, 8);
        chk("repress_mode", mode_o, 1);

        // Into ALL_ON, pause, then the combo recovers to RUN unpaused.
        press(1'b0, 1'b1, 6, 8);
        chk("allon_mode", mode_o, 2);
        chk("allon_led", led_o, 8'h00);
        press(1'b1, 1'b0, 6, 8);
        chk("allon_paused", paused_o, 1);
        press(1'b1, 1'b1, 6, 8);
        chk("combo_mode", mode_o, 0);
        chk("combo_paused", paused_o, 0);

        // Random key traffic with occasional resets.
        for (int it = 0; it < 400; it++) begin
            r   = $urandom_range(0, 19);
            dur = $urandom_range(1, 10);
            if (r == 19) begin
                key0  = 1'($urandom_range(0, 1));
                key1  = 1'($urandom_range(0, 1));
                rst_n = 1'b0;
                @(negedge sys_clk);
                rst_n = 1'b1;
            end else if (r < 8) begin
                key0 = 1'b1; key1 = 1'b1;
            end else if (r < 12) begin
                key0 = 1'b0; key1 = 1'b1;
            end else if (r < 16) begin
                key0 = 1'b1; key1 = 1'b0;
            end else begin
                key0 = 1'b0; key1 = 1'b0;
            end
            repeat (dur) @(negedge sys_clk);
        end
        key0 = 1'b1;
        key1 = 1'b1;
        repeat (20) @(negedge sys_clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
